vga_timing_ctrl: RTL and testbench

Video timing controller for the pixel pipeline. It generates the `h_cnt`/`v_cnt` raster counters and the `dv`/`hs`/`vs` strobes that drive the pixel datapath and the regression bench. It also provides a delay-matched copy of the strobes for the datapath output side. Frames start and stop cleanly on a run request: a frame is never truncated and blanking is never corrupted. The block sits at the head of the video pipeline, clocked by the pixel clock.

---
 rtl/vga_timing_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator: h/v counters, dv/hs/vs strobes, run/drain frame FSM,
// and a PIPE_DLY-deep delay-matched copy of the strobes for the datapath output.
module vga_timing_ctrl #(
  parameter int unsigned HRES     = 1600,
  parameter int unsigned VRES     = 900,
  parameter int unsigned HFP      = 24,
  parameter int unsigned HSW      = 80,
  parameter int unsigned HBP      = 96,
  parameter int unsigned VFP      = 1,
  parameter int unsigned VSW      = 3,
  parameter int unsigned VBP      = 96,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned PIPE_DLY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        vga_dv_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic        dly_dv_o,
  output logic        dly_hs_o,
  output logic        dly_vs_o,
  output logic        frame_start,
  output logic        line_start,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int unsigned HTOT = HRES + HFP + HSW + HBP;
  localparam int unsigned VTOT = VRES + VFP + VSW + VBP;

  if (HTOT > 2047) begin : g_htot_chk
    $error("vga_timing_ctrl: HTOT exceeds 11-bit counter range");
  end
  if (VTOT > 2047) begin : g_vtot_chk
    $error("vga_timing_ctrl: VTOT exceeds 11-bit counter range");
  end
  if (PIPE_DLY > 15) begin : g_dly_chk
    $error("vga_timing_ctrl: PIPE_DLY must be 0..15");
  end

  localparam logic [10:0] H_LAST = 11'(HTOT - 1);
  localparam logic [10:0] V_LAST = 11'(VTOT - 1);
  localparam logic [10:0] H_ACT  = 11'(HRES);
  localparam logic [10:0] V_ACT  = 11'(VRES);
  localparam logic [10:0] HS_BEG = 11'(HRES + HFP);
  localparam logic [10:0] HS_END = 11'(HRES + HFP + HSW);
  localparam logic [10:0] VS_BEG = 11'(VRES + VFP);
  localparam logic [10:0] VS_END = 11'(VRES + VFP + VSW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic [10:0] h_adv_s, v_adv_s;
  logic        last_pix_s, active_s;
  logic        dv_q, dv_d, hs_q, hs_d, vs_q, vs_d;
  logic        fs_q, fs_d, ls_q, ls_d, busy_q, busy_d;
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    last_pix_s = (h_q == H_LAST) && (v_q == V_LAST);
    if (h_q == H_LAST) begin
      h_adv_s = 11'd0;
      if (v_q == V_LAST) begin
        v_adv_s = 11'd0;
      end else begin
        v_adv_s = v_q + 11'd1;
      end
    end else begin
      h_adv_s = h_q + 11'd1;
      v_adv_s = v_q;
    end
  end

  // RUN and DRAIN share one rule: run wins, otherwise stop only after the last pixel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (last_pix_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode the next pixel so they register on the same edge as the counters.
  always_comb begin
    active_s = (state_d != ST_IDLE);
    if ((state_q == ST_IDLE) || !active_s) begin
      h_d = 11'd0;
      v_d = 11'd0;
    end else begin
      h_d = h_adv_s;
      v_d = v_adv_s;
    end
    dv_d = active_s && (h_d < H_ACT) && (v_d < V_ACT);
    if (active_s && (h_d >= HS_BEG) && (h_d < HS_END)) begin
      hs_d = HS_POL;
    end else begin
      hs_d = ~HS_POL;
    end
    if (active_s && (v_d >= VS_BEG) && (v_d < VS_END)) begin
      vs_d = VS_POL;
    end else begin
      vs_d = ~VS_POL;
    end
    fs_d   = (state_d == ST_RUN) && (h_d == 11'd0) && (v_d == 11'd0);
    ls_d   = (state_d == ST_RUN) && (h_d == 11'd0);
    busy_d = active_s;
    if ((state_q != ST_IDLE) && last_pix_s) begin
      fcnt_d = fcnt_q + 16'd1;
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= 11'd0;
      v_q     <= 11'd0;
      dv_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      dv_q    <= dv_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
    end
  end

  if (PIPE_DLY == 0) begin : g_no_dly
    assign dly_dv_o = dv_q;
    assign dly_hs_o = hs_q;
    assign dly_vs_o = vs_q;
  end else begin : g_dly
    logic [2:0] dly_q [PIPE_DLY];

    // Free-running shift so trailing strobes flush out after the frame ends.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(PIPE_DLY); i++) begin
          dly_q[i] <= {1'b0, ~HS_POL, ~VS_POL};
        end
      end else begin
        dly_q[0] <= {dv_q, hs_q, vs_q};
        for (int i = 1; i < int'(PIPE_DLY); i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign {dly_dv_o, dly_hs_o, dly_vs_o} = dly_q[PIPE_DLY-1];
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign vga_dv_o    = dv_q;
  assign vga_hs_o    = hs_q;
  assign vga_vs_o    = vs_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign busy        = busy_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a shrunk 16x9 raster (active 8x4),
// one instance with PIPE_DLY=4 and one with PIPE_DLY=0 sharing the same inputs.
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [10:0] h_cnt, v_cnt, h0, v0;
  logic        dv, hs, vs, dly_dv, dly_hs, dly_vs, fs, ls, busy;
  logic        dv0, hs0, vs0, dly0_dv, dly0_hs, dly0_vs, fs0, ls0, busy0;
  logic [15:0] frame_cnt, frame_cnt0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, start_cyc = 0;
  int ls_cnt = 0, fs_cnt = 0, vs_cnt = 0, vs_bad = 0, dly_bad = 0, d0_bad = 0, disc = 0;
  logic [11:0] hist = 12'd0;
  logic [10:0] ph, pv, eh, ev;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .HRES(8), .VRES(4), .HFP(2), .HSW(3), .HBP(3), .VFP(1), .VSW(2), .VBP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(4)
  ) u_dut (
    .clk(clk), .rst(rst), .run(run), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .vga_dv_o(dv), .vga_hs_o(hs), .vga_vs_o(vs),
    .dly_dv_o(dly_dv), .dly_hs_o(dly_hs), .dly_vs_o(dly_vs),
    .frame_start(fs), .line_start(ls), .busy(busy), .frame_cnt(frame_cnt)
  );

  vga_timing_ctrl #(
    .HRES(8), .VRES(4), .HFP(2), .HSW(3), .HBP(3), .VFP(1), .VSW(2), .VBP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .run(run), .h_cnt(h0), .v_cnt(v0),
    .vga_dv_o(dv0), .vga_hs_o(hs0), .vga_vs_o(vs0),
    .dly_dv_o(dly0_dv), .dly_hs_o(dly0_hs), .dly_vs_o(dly0_vs),
    .frame_start(fs0), .line_start(ls0), .busy(busy0), .frame_cnt(frame_cnt0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; samples on the falling edge and keeps running tallies and the delay model.
  task automatic tick();
    logic       r;
    logic [2:0] exp_dly;
    r = rst;
    @(negedge clk);
    cyc++;
    if (ls) ls_cnt++;
    if (fs) fs_cnt++;
    if (vs) vs_cnt++;
    if (vs && !(v_cnt >= 11'd5 && v_cnt <= 11'd6)) vs_bad++;
    exp_dly = r ? 3'b000 : hist[11:9];
    if ({dly_dv, dly_hs, dly_vs} !== exp_dly) dly_bad++;
    if ({dly0_dv, dly0_hs, dly0_vs} !== {dv0, hs0, vs0}) d0_bad++;
    if ({dv0, hs0, vs0, h0, v0} !== {dv, hs, vs, h_cnt, v_cnt}) d0_bad++;
    hist = r ? {9'd0, dv, hs, vs} : {hist[8:0], dv, hs, vs};
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_h", 32'(h_cnt), 32'd0);
    check("rst_v", 32'(v_cnt), 32'd0);
    check("rst_dv", 32'(dv), 32'd0);
    check("rst_hs", 32'(hs), 32'd0);
    check("rst_vs", 32'(vs), 32'd0);
    check("rst_dly", 32'({dly_dv, dly_hs, dly_vs}), 32'd0);
    check("rst_fs_ls", 32'({fs, ls}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);

    // start latency and horizontal decode
    run = 1'b1;
    tick();
    start_cyc = cyc;
    check("start_hv", 32'({h_cnt, v_cnt}), 32'd0);
    check("start_fs", 32'(fs), 32'd1);
    check("start_ls", 32'(ls), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_dv", 32'(dv), 32'd1);
    check("start_dly_dv", 32'(dly_dv), 32'd0);
    check("start_dly0_dv", 32'(dly0_dv), 32'd1);
    ls_cnt = 0; fs_cnt = 0; vs_cnt = 0;
    repeat (3) tick();
    check("h3_dly_dv", 32'(dly_dv), 32'd0);
    tick();
    check("h4_h", 32'(h_cnt), 32'd4);
    check("h4_dly_dv", 32'(dly_dv), 32'd1);
    repeat (3) tick();
    check("h7_dv", 32'(dv), 32'd1);
    tick();
    check("h8_dv", 32'(dv), 32'd0);
    tick();
    check("h9_hs", 32'(hs), 32'd0);
    tick();
    check("h10_hs", 32'(hs), 32'd1);
    repeat (2) tick();
    check("h12_hs", 32'(hs), 32'd1);
    tick();
    check("h13_hs", 32'(hs), 32'd0);
    tick();
    check("h14_dly_hs", 32'(dly_hs), 32'd1);

    // full frame
    for (int i = 0; i < 300 && fs_cnt == 0; i++) tick();
    check("frame_len", 32'(cyc - start_cyc), 32'd144);
    check("frame2_hv", 32'({h_cnt, v_cnt}), 32'd0);
    check("frame2_fcnt", 32'(frame_cnt), 32'd1);
    check("frame_ls_cnt", 32'(ls_cnt), 32'd9);
    check("frame_vs_cnt", 32'(vs_cnt), 32'd32);

    // run dropped mid-frame: drain to the last pixel, then idle
    for (int i = 0; i < 200 && !(v_cnt == 11'd2 && h_cnt == 11'd0); i++) tick();
    run = 1'b0;
    ls_cnt = 0; fs_cnt = 0;
    ph = h_cnt; pv = v_cnt;
    for (int i = 0; i < 200 && busy; i++) begin
      ph = h_cnt; pv = v_cnt;
      tick();
    end
    check("drain_last_h", 32'(ph), 32'd15);
    check("drain_last_v", 32'(pv), 32'd8);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_hv", 32'({h_cnt, v_cnt}), 32'd0);
    check("drain_fcnt", 32'(frame_cnt), 32'd2);
    check("drain_pulses", 32'(ls_cnt + fs_cnt), 32'd0);
    repeat (5) tick();
    check("idle_hold", 32'({h_cnt, busy, dv, hs, vs, dly_dv}), 32'd0);

    // drop and re-assert run: no discontinuity
    run = 1'b1;
    tick();
    check("restart_fs", 32'(fs), 32'd1);
    for (int i = 0; i < 200 && !(v_cnt == 11'd2 && h_cnt == 11'd0); i++) tick();
    run = 1'b0;
    ls_cnt = 0; disc = 0;
    for (int i = 0; i < 200 && !(v_cnt == 11'd5 && h_cnt == 11'd0); i++) begin
      ph = h_cnt; pv = v_cnt;
      tick();
      eh = (ph == 11'd15) ? 11'd0 : ph + 11'd1;
      ev = (ph == 11'd15) ? pv + 11'd1 : pv;
      if (h_cnt !== eh || v_cnt !== ev || busy !== 1'b1) disc++;
    end
    check("drain_no_ls", 32'(ls_cnt), 32'd0);
    run = 1'b1;
    for (int i = 0; i < 200 && !(v_cnt == 11'd6 && h_cnt == 11'd0); i++) begin
      ph = h_cnt; pv = v_cnt;
      tick();
      eh = (ph == 11'd15) ? 11'd0 : ph + 11'd1;
      ev = (ph == 11'd15) ? pv + 11'd1 : pv;
      if (h_cnt !== eh || v_cnt !== ev || busy !== 1'b1) disc++;
    end
    check("resume_disc", 32'(disc), 32'd0);
    check("resume_ls", 32'(ls), 32'd1);
    fs_cnt = 0;
    for (int i = 0; i < 300 && fs_cnt == 0; i++) tick();
    check("resume_fs", 32'(fs), 32'd1);
    check("resume_fcnt", 32'(frame_cnt), 32'd3);

    // reset mid-frame
    for (int i = 0; i < 200 && !(v_cnt == 11'd3 && h_cnt == 11'd7); i++) tick();
    rst = 1'b1;
    tick();
    check("mrst_hv", 32'({h_cnt, v_cnt}), 32'd0);
    check("mrst_flags", 32'({busy, dv, hs, vs, fs, ls}), 32'd0);
    check("mrst_dly", 32'({dly_dv, dly_hs, dly_vs}), 32'd0);
    check("mrst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst_restart", 32'({fs, busy, dv}), 32'd7);
    check("mrst_restart_hv", 32'({h_cnt, v_cnt}), 32'd0);

    check("vs_outside_rows", 32'(vs_bad), 32'd0);
    check("dly4_model", 32'(dly_bad), 32'd0);
    check("dly0_copy", 32'(d0_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
